// File: rtl/mem_stage_mc_if.sv
// Handshake and operand bundle between execute and the multi-cycle memory stage.
interface mem_stage_mc_if #(
  parameter int WORD = 64
);
  logic            in_valid;
  logic            in_ready;
  logic            uncondbranch;
  logic            branch;
  logic            branch_n;
  logic            mem_read;
  logic            mem_write;
  logic            zero;
  logic [1:0]      size;
  logic            sign_ext;
  logic [WORD-1:0] alu_result;
  logic [WORD-1:0] read_data2;
  logic            pc_src;
  logic [WORD-1:0] read_data;
  logic            out_valid;
  logic            misaligned;

  modport slave (
    input  in_valid, uncondbranch, branch, branch_n, mem_read, mem_write,
           zero, size, sign_ext, alu_result, read_data2,
    output in_ready, pc_src, read_data, out_valid, misaligned
  );

  modport master (
    output in_valid, uncondbranch, branch, branch_n, mem_read, mem_write,
           zero, size, sign_ext, alu_result, read_data2,
    input  in_ready, pc_src, read_data, out_valid, misaligned
  );
endinterface

// File: rtl/mem_stage_mc.sv
// LEGv8 multi-cycle memory stage: little-endian byte memory, sized loads/stores,
// alignment checking and branch resolution behind a valid/ready handshake.
module mem_stage_mc #(
  parameter int WORD        = 64,
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic          im_clk,
  input  logic          im_reset,
  mem_stage_mc_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, next_state;

  logic [3:0]      count;
  logic            c_ub, c_br, c_brn, c_rd, c_wr, c_zero, c_sext;
  logic [1:0]      c_size;
  logic [AW-1:0]   c_addr;
  logic [WORD-1:0] c_wdata;
  logic [7:0]      mem [DEPTH];

  logic            s_ub, s_br, s_brn, s_rd, s_wr, s_zero, s_sext, s_mem;
  logic [1:0]      s_size;
  logic [AW-1:0]   s_addr, align_mask;
  logic [WORD-1:0] raw, ld_val, result;
  logic            mis, pc, accept;
  logic            pc_q, mis_q;
  logic [WORD-1:0] rdata_q;
  logic            unused_hi;

  assign unused_hi = ^bus.alu_result[WORD-1:AW];
  assign accept    = (state == IDLE) && bus.in_valid;

  // In IDLE the live inputs drive the datapath so a zero-latency op can finish in one cycle.
  always_comb begin
    if (state == IDLE) begin
      s_ub = bus.uncondbranch; s_br = bus.branch; s_brn = bus.branch_n;
      s_rd = bus.mem_read;     s_wr = bus.mem_write; s_zero = bus.zero;
      s_size = bus.size;       s_sext = bus.sign_ext;
      s_addr = bus.alu_result[AW-1:0];
    end else begin
      s_ub = c_ub; s_br = c_br; s_brn = c_brn;
      s_rd = c_rd; s_wr = c_wr; s_zero = c_zero;
      s_size = c_size; s_sext = c_sext;
      s_addr = c_addr;
    end
  end

  always_comb begin
    case (s_size)
      2'd0:    align_mask = '0;
      2'd1:    align_mask = AW'(1);
      2'd2:    align_mask = AW'(3);
      default: align_mask = AW'(7);
    endcase
    s_mem = s_rd | s_wr;
    mis   = s_mem && ((s_addr & align_mask) != '0);
    pc    = s_ub | (s_br & (s_zero ^ s_brn));
  end

  always_comb begin
    raw = '0;
    for (int unsigned i = 0; i < 8; i++)
      raw[8*i +: 8] = mem[s_addr + AW'(i)];
    case (s_size)
      2'd0:    ld_val = {{(WORD-8){s_sext & raw[7]}},   raw[7:0]};
      2'd1:    ld_val = {{(WORD-16){s_sext & raw[15]}}, raw[15:0]};
      2'd2:    ld_val = {{(WORD-32){s_sext & raw[31]}}, raw[31:0]};
      default: ld_val = raw;
    endcase
    result = (s_rd && !mis) ? ld_val : '0;
  end

  always_ff @(posedge im_clk or posedge im_reset) begin
    if (im_reset) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.in_valid)
              next_state = (!s_mem || mis || MEM_LATENCY == 0) ? DONE : BUSY;
      BUSY: if (count == 4'd0) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  always_ff @(posedge im_clk or posedge im_reset) begin
    if (im_reset) begin
      count <= '0;
      {c_ub, c_br, c_brn, c_rd, c_wr, c_zero, c_sext} <= '0;
      c_size  <= '0;
      c_addr  <= '0;
      c_wdata <= '0;
      pc_q    <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        count  <= LAT_M1;
        c_ub   <= bus.uncondbranch; c_br <= bus.branch; c_brn <= bus.branch_n;
        c_rd   <= bus.mem_read;     c_wr <= bus.mem_write; c_zero <= bus.zero;
        c_size <= bus.size;         c_sext <= bus.sign_ext;
        c_addr <= bus.alu_result[AW-1:0];
        c_wdata <= bus.read_data2;
      end else if (state == BUSY && count != 4'd0) begin
        count <= count - 4'd1;
      end
      // Results are latched on entry to DONE so they are visible alongside out_valid.
      if (next_state == DONE && state != DONE) begin
        pc_q    <= pc;
        mis_q   <= mis;
        rdata_q <= result;
      end
    end
  end

  // Store commits on the DONE edge, after the load result was already taken.
  always_ff @(posedge im_clk) begin
    if (state == DONE && c_wr && !mis) begin
      for (int unsigned i = 0; i < 8; i++)
        if (i < (32'd1 << c_size))
          mem[c_addr + AW'(i)] <= c_wdata[8*i +: 8];
    end
  end

  assign bus.pc_src     = pc_q;
  assign bus.misaligned = mis_q;
  assign bus.read_data  = rdata_q;
endmodule

// File: tb/tb_mem_stage_mc.sv
// Randomised and directed checks of mem_stage_mc against a byte-array reference model,
// using one instance with MEM_LATENCY=2 and one with MEM_LATENCY=0.
module tb_mem_stage_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v2 = 1'b0, v0 = 1'b0;
  logic        s_ub = 0, s_br = 0, s_brn = 0, s_rd = 0, s_wr = 0, s_zr = 0, s_sx = 0;
  logic [1:0]  s_sz = '0;
  logic [63:0] s_a = '0, s_d = '0;

  mem_stage_mc_if #(.WORD(64)) if2 ();
  mem_stage_mc_if #(.WORD(64)) if0 ();

  assign if2.in_valid = v2;
  assign if0.in_valid = v0;
  assign {if2.uncondbranch, if2.branch, if2.branch_n, if2.mem_read, if2.mem_write, if2.zero, if2.sign_ext}
       = {s_ub, s_br, s_brn, s_rd, s_wr, s_zr, s_sx};
  assign {if0.uncondbranch, if0.branch, if0.branch_n, if0.mem_read, if0.mem_write, if0.zero, if0.sign_ext}
       = {s_ub, s_br, s_brn, s_rd, s_wr, s_zr, s_sx};
  assign if2.size = s_sz;       assign if0.size = s_sz;
  assign if2.alu_result = s_a;  assign if0.alu_result = s_a;
  assign if2.read_data2 = s_d;  assign if0.read_data2 = s_d;

  mem_stage_mc #(.WORD(64), .DEPTH(256), .MEM_LATENCY(2)) dut2 (.im_clk(clk), .im_reset(rst), .bus(if2));
  mem_stage_mc #(.WORD(64), .DEPTH(256), .MEM_LATENCY(0)) dut0 (.im_clk(clk), .im_reset(rst), .bus(if0));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        pc;
    logic [63:0] rd;
    logic        mis;
    int          lat;
    int          nrdy;
  } res_t;

  logic [7:0] m2 [256];
  logic [7:0] m0 [256];

  function automatic logic [7:0] mget(int sel, int idx);
    return (sel == 2) ? m2[idx] : m0[idx];
  endfunction

  function automatic logic ov(int sel);  return (sel == 2) ? if2.out_valid : if0.out_valid; endfunction
  function automatic logic rdy(int sel); return (sel == 2) ? if2.in_ready  : if0.in_ready;  endfunction

  // Reference: byte array, reads before writes, latency from the operation kind.
  task automatic model_op(input int sel, input logic ub, br, brn, rd, wr, zr, input logic [1:0] sz,
                          input logic sx, input logic [63:0] a, d, output res_t e);
    int a8 = int'(a % 256);
    int n  = 1 << sz;
    logic [63:0] val = '0;
    e.mis = (rd | wr) && (a8 % n != 0);
    e.pc  = ub | (br & (zr ^ brn));
    if (rd && !e.mis) begin
      for (int i = 0; i < n; i++) val = val | (64'(mget(sel, (a8 + i) % 256)) << (8 * i));
      if (sx && n < 8 && val[8*n-1]) val = val | ~((64'd1 << (8 * n)) - 64'd1);
    end
    if (wr && !e.mis)
      for (int i = 0; i < n; i++) begin
        if (sel == 2) m2[(a8 + i) % 256] = d[8*i +: 8];
        else          m0[(a8 + i) % 256] = d[8*i +: 8];
      end
    e.rd   = (rd && !e.mis) ? val : 64'd0;
    e.lat  = (!(rd | wr) || e.mis) ? 1 : 1 + ((sel == 2) ? 2 : 0);
    e.nrdy = e.lat;
  endtask

  task automatic run_op(input int sel, input logic ub, br, brn, rd, wr, zr, input logic [1:0] sz,
                        input logic sx, input logic [63:0] a, d, output res_t r);
    r.pc = 1'bx; r.rd = 'x; r.mis = 1'bx; r.lat = -1; r.nrdy = 0;
    @(negedge clk);
    {s_ub, s_br, s_brn, s_rd, s_wr, s_zr, s_sx} = {ub, br, brn, rd, wr, zr, sx};
    s_sz = sz; s_a = a; s_d = d;
    if (sel == 2) v2 = 1'b1; else v0 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0; v0 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (!rdy(sel)) r.nrdy++;
      if (ov(sel)) begin
        r.lat = c;
        r.pc  = (sel == 2) ? if2.pc_src     : if0.pc_src;
        r.rd  = (sel == 2) ? if2.read_data  : if0.read_data;
        r.mis = (sel == 2) ? if2.misaligned : if0.misaligned;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic xact(input int sel, input logic ub, br, brn, rd, wr, zr, input logic [1:0] sz,
                      input logic sx, input logic [63:0] a, d, output res_t act, output res_t exp);
    model_op(sel, ub, br, brn, rd, wr, zr, sz, sx, a, d, exp);
    run_op(sel, ub, br, brn, rd, wr, zr, sz, sx, a, d, act);
  endtask

  task automatic test_reset;
    total++;
    if ({if2.pc_src, if2.read_data, if2.out_valid, if2.misaligned, if2.in_ready} !== {1'b0, 64'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_dut2 pc=%b rd=%h ov=%b mis=%b rdy=%b want 0 0 0 0 1",
                      if2.pc_src, if2.read_data, if2.out_valid, if2.misaligned, if2.in_ready);
    end
    total++;
    if ({if0.pc_src, if0.read_data, if0.out_valid, if0.misaligned, if0.in_ready} !== {1'b0, 64'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_dut0 pc=%b rd=%h ov=%b mis=%b rdy=%b want 0 0 0 0 1",
                      if0.pc_src, if0.read_data, if0.out_valid, if0.misaligned, if0.in_ready);
    end
  endtask

  task automatic test_init;
    res_t a, e;
    int errs = 0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 32; i++) begin
        xact(s == 0 ? 2 : 0, 0, 0, 0, 0, 1, 0, 2'd3, 0, 64'(i * 8), {$urandom, $urandom}, a, e);
        if (a.lat != e.lat) errs++;
      end
    total++;
    if (errs != 0) begin bad++; $display("FAIL init_store_latency errors=%0d want 0", errs); end
  endtask

  task automatic test_abort;
    res_t a, e;
    int seen = 0;
    @(negedge clk);
    {s_ub, s_br, s_brn, s_rd, s_wr, s_zr, s_sx} = 7'b0000100;
    s_sz = 2'd0; s_a = 64'h10; s_d = 64'hAA; v2 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0;
    rst = 1'b1; #2; rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (if2.out_valid) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen != 0 || if2.in_ready !== 1'b1) begin
      bad++; $display("FAIL abort_no_valid out_valid_count=%0d in_ready=%b want 0 1", seen, if2.in_ready);
    end
    xact(2, 0, 0, 0, 1, 0, 0, 2'd0, 0, 64'h10, 0, a, e);
    total++;
    if (a.rd !== e.rd) begin bad++; $display("FAIL abort_mem_kept got=%h want=%h", a.rd, e.rd); end
  endtask

  task automatic test_dword;
    res_t a, e;
    xact(2, 0, 0, 0, 0, 1, 0, 2'd3, 0, 64'h08, 64'h1122334455667788, a, e);
    total++;
    if (a.lat != 3 || a.nrdy != 3) begin bad++; $display("FAIL dword_store_latency lat=%0d nrdy=%0d want 3 3", a.lat, a.nrdy); end
    xact(2, 0, 0, 0, 1, 0, 0, 2'd0, 0, 64'h08, 0, a, e);
    total++;
    if (a.rd !== 64'h88 || a.lat != 3) begin bad++; $display("FAIL dword_byte0 got=%h lat=%0d want 88 3", a.rd, a.lat); end
    xact(2, 0, 0, 0, 1, 0, 0, 2'd0, 0, 64'h0F, 0, a, e);
    total++;
    if (a.rd !== 64'h11 || a.lat != 3) begin bad++; $display("FAIL dword_byte7 got=%h lat=%0d want 11 3", a.rd, a.lat); end
    total++;
    if (if2.read_data !== 64'h11) begin bad++; $display("FAIL hold_read_data got=%h want 11", if2.read_data); end
  endtask

  task automatic test_sign;
    res_t a, e;
    xact(2, 0, 0, 0, 0, 1, 0, 2'd0, 0, 64'h20, 64'h80, a, e);
    xact(2, 0, 0, 0, 1, 0, 0, 2'd0, 1, 64'h20, 0, a, e);
    total++;
    if (a.rd !== 64'hFFFFFFFFFFFFFF80) begin bad++; $display("FAIL sign_ext_byte got=%h want ffffffffffffff80", a.rd); end
    xact(2, 0, 0, 0, 1, 0, 0, 2'd0, 0, 64'h20, 0, a, e);
    total++;
    if (a.rd !== 64'h80) begin bad++; $display("FAIL zero_ext_byte got=%h want 80", a.rd); end
  endtask

  task automatic test_misalign;
    res_t a, e;
    xact(2, 0, 0, 0, 1, 0, 0, 2'd1, 0, 64'h21, 0, a, e);
    total++;
    if (a.mis !== 1'b1 || a.rd !== 64'd0 || a.lat != 1) begin
      bad++; $display("FAIL misaligned_half mis=%b rd=%h lat=%0d want 1 0 1", a.mis, a.rd, a.lat);
    end
    xact(2, 0, 0, 0, 0, 1, 0, 2'd2, 0, 64'h22, 64'h12345678, a, e);
    xact(2, 0, 0, 0, 1, 0, 0, 2'd3, 0, 64'h20, 0, a, e);
    total++;
    if (a.rd !== e.rd || a.mis !== 1'b0) begin bad++; $display("FAIL misaligned_store_untouched got=%h want=%h", a.rd, e.rd); end
    xact(2, 0, 0, 0, 0, 1, 0, 2'd2, 0, 64'h104, 64'hDEADBEEF, a, e);
    xact(2, 0, 0, 0, 1, 0, 0, 2'd2, 0, 64'h04, 0, a, e);
    total++;
    if (a.rd !== 64'hDEADBEEF) begin bad++; $display("FAIL addr_wrap got=%h want deadbeef", a.rd); end
  endtask

  task automatic test_branch;
    res_t a, e;
    logic [3:0] tbl [4] = '{4'b0110, 4'b0111, 4'b0101, 4'b1000}; // {ub, br, zero, br_n}
    logic       want [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      xact(2, tbl[i][3], tbl[i][2], tbl[i][0], 0, 0, tbl[i][1], 2'd0, 0, 64'h0, 0, a, e);
      total++;
      if (a.pc !== want[i] || a.lat != 1 || a.rd !== 64'd0) begin
        bad++; $display("FAIL branch_%0d pc=%b lat=%0d rd=%h want %b 1 0", i, a.pc, a.lat, a.rd, want[i]);
      end
    end
  endtask

  task automatic test_rmw;
    res_t a, e;
    for (int s = 0; s < 2; s++) begin
      int sel = (s == 0) ? 2 : 0;
      xact(sel, 0, 0, 0, 0, 1, 0, 2'd3, 0, 64'h30, 64'h5, a, e);
      xact(sel, 0, 0, 0, 1, 1, 0, 2'd3, 0, 64'h30, 64'h9, a, e);
      total++;
      if (a.rd !== 64'h5 || a.lat != ((sel == 2) ? 3 : 1)) begin
        bad++; $display("FAIL rmw_old_%0d got=%h lat=%0d want 5 %0d", sel, a.rd, a.lat, (sel == 2) ? 3 : 1);
      end
      xact(sel, 0, 0, 0, 1, 0, 0, 2'd3, 0, 64'h30, 0, a, e);
      total++;
      if (a.rd !== 64'h9) begin bad++; $display("FAIL rmw_new_%0d got=%h want 9", sel, a.rd); end
    end
  endtask

  task automatic test_random;
    res_t a, e;
    for (int i = 0; i < 300; i++) begin
      int sel = (i % 2 == 0) ? 2 : 0;
      logic [6:0] f = 7'($urandom);
      logic [1:0] sz = 2'($urandom);
      logic [63:0] ad = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) ad = 64'(sz == 0 ? ad : (ad & ~64'((1 << sz) - 1)));
      xact(sel, f[0], f[1], f[2], f[3], f[4], f[5], sz, f[6], ad, {$urandom, $urandom}, a, e);
      total++;
      if (a.pc !== e.pc || a.rd !== e.rd || a.mis !== e.mis || a.lat != e.lat || a.nrdy != e.nrdy) begin
        bad++;
        $display("FAIL random_%0d dut%0d pc=%b rd=%h mis=%b lat=%0d nrdy=%0d want pc=%b rd=%h mis=%b lat=%0d nrdy=%0d",
                 i, sel, a.pc, a.rd, a.mis, a.lat, a.nrdy, e.pc, e.rd, e.mis, e.lat, e.nrdy);
      end
    end
  endtask

  initial begin
    #23 rst = 1'b0;
    #1;
    test_reset;
    test_init;
    test_abort;
    test_dword;
    test_sign;
    test_misalign;
    test_branch;
    test_rmw;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage_mc.md
Name: mem_stage_mc

Overview:
Parametrised multi-cycle memory stage for the LEGv8 datapath.
- Replaces the single-cycle memory stage with a handshaked block that holds a byte-addressed, little-endian data memory.
- Supports byte, half, word and doubleword loads and stores, with optional sign extension and alignment checking.
- Resolves the branch decision, including CBNZ sense, and presents it together with the memory result.
- Sits between execute and write-back; the upstream pipeline stalls on in_ready=0.

Parameters:
WORD, 64, datapath width in bits (must be 64).
DEPTH, 256, data memory size in bytes (power of two).
MEM_LATENCY, 2, extra cycles taken by load/store operations (0..15).

Ports:
im_clk  input  1  stage clock, rising edge.
im_reset  input  1  asynchronous reset, active-high.
in_valid  input  1  request present on the inputs.
in_ready  output  1  stage can accept; 1 only in IDLE.
uncondbranch  input  1  unconditional branch.
branch  input  1  conditional branch (CBZ/CBNZ).
branch_n  input  1  invert zero sense (CBNZ).
mem_read  input  1  load request.
mem_write  input  1  store request.
zero  input  1  ALU zero flag.
size  input  2  access size: 0=byte, 1=half, 2=word, 3=dword.
sign_ext  input  1  sign-extend the load result.
alu_result  input  WORD  byte address.
read_data2  input  WORD  store data; low bytes are used for size.
pc_src  output  1  branch taken.
read_data  output  WORD  load result.
out_valid  output  1  one-cycle completion pulse.
misaligned  output  1  alignment fault for this completion.

Behaviour:
- Reset (async, active-high):
  - State=IDLE, counter=0.
  - pc_src=0, read_data=0, out_valid=0, misaligned=0, in_ready=1.
  - Memory contents are not cleared.
  - Reset asserted mid-operation aborts the operation: a pending store is not written, and no out_valid is produced.
- Acceptance: on a rising edge with in_valid=1 and state=IDLE, all inputs are captured into internal registers. Inputs are ignored outside IDLE.
- Branch decision, computed from the captured inputs: pc_src = uncondbranch | (branch & (zero ^ branch_n)).
- Address and alignment:
  - Address = alu_result[log2(DEPTH)-1:0]; upper bits are ignored, so addresses wrap.
  - Misaligned when address mod (1<<size) != 0.
  - A misaligned memory operation performs no access; it completes with misaligned=1 and read_data=0.
- FSM:
  - IDLE -> DONE on accepting a non-memory op, or a misaligned memory op, or any memory op when MEM_LATENCY=0.
  - IDLE -> BUSY on accepting an aligned memory op with MEM_LATENCY>0; counter loads MEM_LATENCY-1.
  - BUSY: counter decrements each cycle; at 0 -> DONE.
  - DONE (exactly one cycle): out_valid=1; the store writes the memory on this edge; then -> IDLE.
- Latency:
  - Non-memory op: out_valid in the cycle after acceptance (1 cycle).
  - Aligned load/store: 1+MEM_LATENCY cycles.
  - in_ready=0 in BUSY and DONE, so back-to-back throughput is one op per 2+MEM_LATENCY cycles for memory ops and one per 2 cycles for non-memory ops.
- Loads:
  - Bytes are assembled little-endian from the address.
  - Zero-extended, or sign-extended from bit 8·2^size−1 when sign_ext=1. sign_ext is ignored for size=3.
- Stores: write the low 2^size bytes of read_data2 starting at the address; other bytes are unchanged.
- mem_read and mem_write both set: the write is performed, and read_data returns the pre-write data (read-before-write).
- Outputs pc_src, read_data and misaligned are registered at DONE and hold until the next completion.
- pc_src is meaningful only with out_valid. read_data is 0 for non-load completions.

Test Plan:
- Reset during BUSY of a store of 0xAA to 0x10: im_reset pulse -> out_valid stays 0, in_ready=1; a later byte load from 0x10 returns the prior value.
- Aligned dword store of 0x1122334455667788 to 0x08, then byte loads at 0x08 and 0x0F -> read_data 0x88 and 0x11; each out_valid arrives 3 cycles after acceptance (MEM_LATENCY=2); in_ready=0 for 3 cycles.
- Byte store 0x80 to 0x20, then byte load with sign_ext=1 -> 0xFFFFFFFFFFFFFF80; with sign_ext=0 -> 0x0000000000000080.
- Half load at 0x21 -> misaligned=1, read_data=0, out_valid after 1 cycle; memory unchanged. Word store to address 0x104 (DEPTH=256) -> data lands at 0x04.
- Branch table, non-memory ops: branch=1,zero=1,branch_n=0 -> pc_src=1; branch_n=1 -> 0; zero=0,branch_n=1 -> 1; uncondbranch=1 -> 1; each with out_valid after 1 cycle.
- mem_read=mem_write=1, dword at 0x30 holding 0x5, write 0x9 -> read_data=0x5; a following load returns 0x9. Repeat with MEM_LATENCY=0 -> latency 1.
